// File: rtl/neuron_mac_lanes.sv
// Multi-lane sequential MAC neuron: dot product + bias, fixed-point rescale, optional ReLU, saturation.
// Latency: job accepted at edge E, valid_out rises after edge E+N+1, N = ceil(INPUT_WIDTH/LANES).
// Backpressure: ready_in only in IDLE; result held in DONE with valid_out high until ready_out.
module neuron_mac_lanes #(
  parameter int INPUT_WIDTH = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 48,
  parameter int LANES       = 1,
  parameter int FRAC_BITS   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] a_in [INPUT_WIDTH],
  input  logic signed [DATA_WIDTH-1:0] w_in [INPUT_WIDTH],
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic                         relu_en,
  input  logic                         valid_in,
  output logic                         ready_in,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic                         sat_flag
);

  localparam int N     = (INPUT_WIDTH + LANES - 1) / LANES;
  // Operand registers are padded to a whole number of lane groups so the
  // shifted-in zeros make out-of-range lanes contribute nothing.
  localparam int NL    = N * LANES;
  localparam int IDX_W = $clog2(NL + 1);

  localparam logic signed [DATA_WIDTH-1:0] DMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0]  AMAX = ACC_WIDTH'(DMAX);
  localparam logic signed [ACC_WIDTH-1:0]  AMIN = ACC_WIDTH'(DMIN);

  typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

  state_t                         state, state_nxt;
  logic signed [DATA_WIDTH-1:0]   a_r [NL];
  logic signed [DATA_WIDTH-1:0]   w_r [NL];
  logic signed [DATA_WIDTH-1:0]   bias_r;
  logic                           relu_r;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic        [IDX_W-1:0]        idx;

  logic                           accept;
  logic                           last_step;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    lane_sum;
  logic signed [ACC_WIDTH-1:0]    s_sum;
  logic signed [ACC_WIDTH-1:0]    r_val;
  logic signed [DATA_WIDTH-1:0]   a_nxt;
  logic                           sat_nxt;

  assign ready_in  = (state == IDLE) && !rst;
  assign accept    = valid_in && ready_in;
  assign last_step = (int'(idx) + LANES >= INPUT_WIDTH);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = MAC;
      MAC:  if (last_step) state_nxt = BIAS;
      BIAS:                state_nxt = DONE;
      DONE: if (ready_out) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Sum of the LANES products at the head of the operand shift registers.
  always_comb begin
    prod     = '0;
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      prod     = a_r[k] * w_r[k];
      lane_sum = lane_sum + ACC_WIDTH'(prod);
    end
  end

  // Output stage: bias alignment, floor rescale, ReLU, clamp to DATA_WIDTH.
  always_comb begin
    s_sum = acc + (ACC_WIDTH'(bias_r) <<< FRAC_BITS);
    r_val = s_sum >>> FRAC_BITS;
    if (relu_r && (r_val < 0)) r_val = '0;
    a_nxt   = r_val[DATA_WIDTH-1:0];
    sat_nxt = 1'b0;
    if (r_val > AMAX) begin
      a_nxt   = DMAX;
      sat_nxt = 1'b1;
    end else if (r_val < AMIN) begin
      a_nxt   = DMIN;
      sat_nxt = 1'b1;
    end
  end

  // Datapath: capture job, accumulate lane groups, register the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      bias_r    <= '0;
      relu_r    <= 1'b0;
      a_out     <= '0;
      sat_flag  <= 1'b0;
      valid_out <= 1'b0;
      for (int i = 0; i < NL; i++) begin
        a_r[i] <= '0;
        w_r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (accept) begin
          for (int i = 0; i < INPUT_WIDTH; i++) begin
            a_r[i] <= a_in[i];
            w_r[i] <= w_in[i];
          end
          for (int i = INPUT_WIDTH; i < NL; i++) begin
            a_r[i] <= '0;
            w_r[i] <= '0;
          end
          bias_r <= bias;
          relu_r <= relu_en;
          acc    <= '0;
          idx    <= '0;
        end
        MAC: begin
          acc <= acc + lane_sum;
          idx <= idx + IDX_W'(LANES);
          for (int i = 0; i < NL - LANES; i++) begin
            a_r[i] <= a_r[i+LANES];
            w_r[i] <= w_r[i+LANES];
          end
          for (int i = NL - LANES; i < NL; i++) begin
            a_r[i] <= '0;
            w_r[i] <= '0;
          end
        end
        BIAS: begin
          a_out     <= a_nxt;
          sat_flag  <= sat_nxt;
          valid_out <= 1'b1;
        end
        DONE: if (ready_out) valid_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
